// File: rtl/index_mask_decoder.sv
// index_mask_decoder
//   Accumulates a stream of bit-position beats into an N-bit mask. It presents
//   the completed mask with its population count and a sticky error flag. The
//   error flag records any out-of-range or duplicate index.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   an index beat is offered
//   in_ready   out  beat accepted (high while accumulating)
//   in_index   in   bit position to set (IW bits)
//   in_hit     in   in_index is meaningful; 0 marks an empty beat
//   in_last    in   beat closes the current mask
//   out_valid  out  completed mask presented
//   out_ready  in   consumer accepts the mask
//   out_mask   out  accumulated one-hot OR of accepted indices
//   out_count  out  popcount of out_mask (IW bits)
//   out_err    out  mask saw an out-of-range or duplicate index
module index_mask_decoder #(
  parameter int unsigned NumberOfElement = 8,
  localparam int unsigned IW = $clog2(NumberOfElement) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IW-1:0]              in_index,
  input  logic                       in_hit,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NumberOfElement-1:0] out_mask,
  output logic [IW-1:0]              out_count,
  output logic                       out_err
);

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [NumberOfElement-1:0] mask_q, mask_d;
  logic [IW-1:0]              count_q, count_d;
  logic                       err_q, err_d;

  logic [NumberOfElement-1:0] onehot;
  logic                       in_range;
  logic                       dup;
  logic                       in_fire;
  logic                       out_fire;

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == EMIT);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Compare against each legal position instead of indexing. An index at or
  // beyond N then decodes to all-zero and never selects past the mask.
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NumberOfElement; i++) begin
      onehot[i] = (in_index == IW'(i));
    end
  end

  assign in_range = |onehot;
  assign dup      = |(onehot & mask_q);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    err_d   = err_q;
    unique case (state_q)
      ACCUM: begin
        if (in_fire) begin
          if (in_hit) begin
            if (!in_range || dup) begin
              err_d = 1'b1;
            end else begin
              mask_d  = mask_q | onehot;
              count_d = count_q + IW'(1);
            end
          end
          if (in_last) begin
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (out_fire) begin
          state_d = ACCUM;
          mask_d  = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      mask_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign out_mask  = mask_q;
  assign out_count = count_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_index_mask_decoder.sv
module tb_index_mask_decoder;

  localparam int unsigned N  = 8;
  localparam int unsigned IW = $clog2(N) + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_index;
  logic          in_hit;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_mask;
  logic [IW-1:0] out_count;
  logic          out_err;

  int checks;
  int failures;

  index_mask_decoder #(.NumberOfElement(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_index  (in_index),
    .in_hit    (in_hit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mask  (out_mask),
    .out_count (out_count),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [N-1:0] m,
                           input logic [IW-1:0] c, input logic e);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    check({tag, ".in_ready"},  32'(in_ready),  32'(!v));
    check({tag, ".mask"},      32'(out_mask),  32'(m));
    check({tag, ".count"},     32'(out_count), 32'(c));
    check({tag, ".err"},       32'(out_err),   32'(e));
  endtask

  // Offer one beat for a single rising edge, then withdraw it.
  task automatic beat(input int idx, input logic hit, input logic last);
    in_valid = 1'b1;
    in_index = IW'(idx);
    in_hit   = hit;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_hit   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_index  = '0;
    in_hit    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    tick(); tick();
    check_out("reset", 1'b0, 8'h00, 4'd0, 1'b0);
    rst = 1'b0;

    // Beats 1,3,6 -> 0x4A, with idle cycles holding the partial mask
    out_ready = 1'b1;
    beat(1, 1'b1, 1'b0);
    check_out("partial1", 1'b0, 8'h02, 4'd1, 1'b0);
    tick();
    check_out("idle_hold", 1'b0, 8'h02, 4'd1, 1'b0);
    beat(3, 1'b1, 1'b0);
    beat(6, 1'b1, 1'b1);
    check_out("mask4A", 1'b1, 8'h4A, 4'd3, 1'b0);
    tick();
    check_out("back_accum", 1'b0, 8'h00, 4'd0, 1'b0);

    // Duplicate index, then out-of-range index in a new mask
    beat(2, 1'b1, 1'b0);
    beat(2, 1'b1, 1'b1);
    check_out("dup", 1'b1, 8'h04, 4'd1, 1'b1);
    tick();
    check_out("dup_cleared", 1'b0, 8'h00, 4'd0, 1'b0);
    beat(9, 1'b1, 1'b0);
    check_out("oor_partial", 1'b0, 8'h00, 4'd0, 1'b1);
    beat(0, 1'b0, 1'b1);
    check_out("oor_emit", 1'b1, 8'h00, 4'd0, 1'b1);
    tick();

    // Single empty beat closes an all-zero mask; index must be ignored
    beat(3, 1'b0, 1'b1);
    check_out("empty", 1'b1, 8'h00, 4'd0, 1'b0);
    tick();

    // Back-pressure in EMIT with a beat waiting
    out_ready = 1'b0;
    beat(4, 1'b1, 1'b1);
    in_valid = 1'b1;
    in_index = IW'(5);
    in_hit   = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("stall", 1'b1, 8'h10, 4'd1, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    check_out("no_bypass", 1'b0, 8'h00, 4'd0, 1'b0);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check_out("held_beat", 1'b1, 8'h20, 4'd1, 1'b0);
    out_ready = 1'b1;
    tick();
    check_out("held_done", 1'b0, 8'h00, 4'd0, 1'b0);

    // Full mask
    for (int i = 0; i < 8; i++) begin
      beat(i, 1'b1, (i == 7));
    end
    check_out("full", 1'b1, 8'hFF, 4'd8, 1'b0);
    tick();

    // Asynchronous reset mid-accumulation
    beat(5, 1'b1, 1'b0);
    check_out("pre_rst", 1'b0, 8'h20, 4'd1, 1'b0);
    #2 rst = 1'b1;
    #1 check_out("async_rst", 1'b0, 8'h00, 4'd0, 1'b0);
    #1 rst = 1'b0;
    beat(0, 1'b1, 1'b1);
    check_out("post_rst", 1'b1, 8'h01, 4'd1, 1'b0);
    tick();
    check_out("post_rst_done", 1'b0, 8'h00, 4'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/index_mask_decoder.md
INDEX_MASK_DECODER -- requirements
Module: index_mask_decoder

Interface
REQ-001 SHALL have parameter NumberOfElement, default 8, giving the mask width N (legal range N >= 2).
REQ-002 SHALL define IW = $clog2(NumberOfElement)+1 as the width of every index and count port.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: an index beat is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the offered beat.
REQ-007 SHALL have port in_index, input, IW bits: the bit position to set.
REQ-008 SHALL have port in_hit, input, 1 bit: in_index is meaningful; 0 means an empty beat.
REQ-009 SHALL have port in_last, input, 1 bit: the beat closes the current mask.
REQ-010 SHALL have port out_valid, output, 1 bit: a completed mask is presented.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the mask.
REQ-012 SHALL have port out_mask, output, N bits: the accumulated one-hot OR of the accepted indices.
REQ-013 SHALL have port out_count, output, IW bits: number of set bits in out_mask.
REQ-014 SHALL have port out_err, output, 1 bit: the mask saw at least one out-of-range or duplicate index.

Function
REQ-015 SHALL implement a two-state FSM with states ACCUM and EMIT.
REQ-016 SHALL assert in_ready=1 and out_valid=0 in ACCUM.
REQ-017 SHALL assert in_ready=0 and out_valid=1 in EMIT.
REQ-018 SHALL define an input fire as in_valid && in_ready, and an output fire as out_valid && out_ready.
REQ-019 SHALL, on an input fire with in_hit=1 and in_index < N, set mask bit in_index and increment count if that bit was clear.
REQ-020 SHALL, on an input fire with in_hit=1 and in_index < N where the bit is already set, leave mask and count unchanged and set the sticky error flag.
REQ-021 SHALL, on an input fire with in_hit=1 and in_index >= N, leave mask and count unchanged and set the sticky error flag.
REQ-022 SHALL, on an input fire with in_hit=0, leave mask, count and the error flag unchanged; in_index is ignored.
REQ-023 SHALL, on an input fire with in_last=1, apply that beat's update and move to EMIT on the same edge, so out_valid rises the cycle after the last beat.
REQ-024 SHALL, in EMIT, hold out_mask, out_count and out_err stable until the output fire.
REQ-025 SHALL, on an output fire, return to ACCUM and clear mask, count and the error flag on the same edge.
REQ-026 SHALL drive out_mask, out_count and out_err directly from registers in every state, so the partial accumulation is visible during ACCUM.
REQ-027 SHALL NOT bypass: a new beat cannot be accepted in the cycle its predecessor mask is consumed.
REQ-028 SHALL keep out_count equal to popcount(out_mask) at all times; its maximum value is N, which fits in IW bits.
REQ-029 SHALL let a mask of any length (1 to unbounded beats) complete, including an all-empty mask of zero bits.
REQ-030 SHALL cause no state change when in_valid=0 in ACCUM or out_ready=0 in EMIT.

Reset
REQ-031 SHALL, while rst=1, force state=ACCUM, out_mask=0, out_count=0, out_err=0, out_valid=0 and in_ready=1, independent of clk.
REQ-032 SHALL, on an assertion of rst mid-accumulation or in EMIT, discard the pending mask with no output fire.
REQ-033 SHALL accept the first beat at the first rising edge after rst deasserts.

Verification (N=8, IW=4)
REQ-034 SHALL be verified with: beats idx 1, 3, 6 (in_hit=1), last on 6, out_ready=1 -> out_valid one cycle after idx 6, out_mask=0x4A, out_count=3, out_err=0, back in ACCUM on the next cycle.
REQ-035 SHALL be verified with: beats idx 2, 2 (last), then idx 9 -> first mask out_mask=0x04, count=1, err=1; idx 9 in a new mask gives mask=0, count=0, err=1.
REQ-036 SHALL be verified with: a single beat in_hit=0, in_last=1 -> out_mask=0, count=0, err=0, out_valid=1.
REQ-037 SHALL be verified with: out_ready held 0 for 5 cycles in EMIT while in_valid=1 -> in_ready=0 throughout, outputs stable, no beat lost; the beat is accepted the cycle after the output fire.
REQ-038 SHALL be verified with: all 8 indices 0..7 then last -> out_mask=0xFF, out_count=8.
REQ-039 SHALL be verified with: rst pulsed asynchronously after idx 5 is accepted -> outputs zero immediately, and a following mask of idx 0 gives out_mask=0x01.
